mul_iter: RTL

//  Iterative radix-2 shift-add multiplier; companion to the multi-cycle divider in the EX stage.

---
 rtl/mul_pkg.sv | 12 +
 rtl/mul_iter_if.sv | 24 ++
 rtl/mul_abs.sv | 12 +
 rtl/mul_iter.sv | 115 +++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared state encoding and sizing for the iterative multiplier
package mul_pkg;
  localparam int MUL_W     = 32;
  localparam int MUL_CNT_W = $clog2(MUL_W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } mul_state_t;
endpackage

// File: rtl/mul_iter_if.sv
// rtl/mul_iter_if.sv - start/complete handshake bundle between EX stage and mul_iter
interface mul_iter_if
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W
);
  logic               mul;
  logic               mul_signed;
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic [2*WIDTH-1:0] p;
  logic               busy;
  logic               complete;

  modport master (
    output mul, mul_signed, x, y,
    input  p, busy, complete
  );

  modport slave (
    input  mul, mul_signed, x, y,
    output p, busy, complete
  );
endinterface

// File: rtl/mul_abs.sv
// rtl/mul_abs.sv - conditional two's-complement negate, used for operand magnitude and result sign fix
module mul_abs
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic [WIDTH-1:0] i_in,
  input  logic             i_neg_en,
  output logic [WIDTH-1:0] o_out
);
  assign o_out = i_neg_en ? (~i_in + 1'b1) : i_in;
endmodule

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - radix-2 shift-add multiplier, WIDTH+2 cycle latency
// MUL_EARLY_TERM_EN: stop iterating once the remaining multiplier bits are all zero.
module mul_iter
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_W
) (
  input  logic           mul_clk,
  input  logic           reset,
  mul_iter_if.slave      bus
);
  localparam int              CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  mul_state_t          r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*WIDTH-1:0]  r_acc;
  logic [2*WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]    r_mplier;
  logic                r_sign;
  logic [2*WIDTH-1:0]  r_p;
  logic                r_busy;
  logic                r_complete;

  logic [WIDTH-1:0]    w_x_abs;
  logic [WIDTH-1:0]    w_y_abs;
  logic [2*WIDTH-1:0]  w_fix_out;
  logic [2*WIDTH-1:0]  w_acc_next;
  logic [WIDTH-1:0]    w_mplier_next;
  logic                w_x_neg;
  logic                w_y_neg;
  logic                w_last;

  assign w_x_neg = bus.mul_signed & bus.x[WIDTH-1];
  assign w_y_neg = bus.mul_signed & bus.y[WIDTH-1];

  mul_abs #(.WIDTH(WIDTH)) u_abs_x (
    .i_in     (bus.x),
    .i_neg_en (w_x_neg),
    .o_out    (w_x_abs)
  );

  mul_abs #(.WIDTH(WIDTH)) u_abs_y (
    .i_in     (bus.y),
    .i_neg_en (w_y_neg),
    .o_out    (w_y_abs)
  );

  mul_abs #(.WIDTH(2*WIDTH)) u_fix (
    .i_in     (r_acc),
    .i_neg_en (r_sign),
    .o_out    (w_fix_out)
  );

  assign w_acc_next    = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mplier_next = r_mplier >> 1;

`ifdef MUL_EARLY_TERM_EN
  assign w_last = (r_cnt == LAST) || (w_mplier_next == '0);
`else
  assign w_last = (r_cnt == LAST);
`endif

  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_sign     <= 1'b0;
      r_p        <= '0;
      r_busy     <= 1'b0;
      r_complete <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.mul) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_x_abs};
            r_mplier <= w_y_abs;
            r_sign   <= w_x_neg ^ w_y_neg;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= CALC;
          end
        end
        CALC: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= w_mplier_next;
          r_cnt    <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= FIX;
          end
        end
        FIX: begin
          r_p        <= w_fix_out;
          r_complete <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          r_complete <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.p        = r_p;
  assign bus.busy     = r_busy;
  assign bus.complete = r_complete;
endmodule
